// File: rtl/matrix_pkg.sv
// Shared constants and types for the 2x2 matrix multiply-accumulate block.
// Index-to-accumulator mapping, FSM states and packed result layout.
package matrix_pkg;

    localparam int ELEM_W   = 3;
    localparam int ACC_W    = 2 * ELEM_W + 1;
    localparam int PROD_W   = 2 * ELEM_W;
    localparam int LAST_IDX = 7;
    localparam int IDX_W    = 4;
    localparam int ACC_N    = 4;
    localparam int SEL_W    = 2;
    localparam int RES_W    = ACC_N * ACC_W;

    // entry_in[2:1] selects the accumulator
    localparam logic [SEL_W-1:0] ACC_C00 = 2'd0;
    localparam logic [SEL_W-1:0] ACC_C01 = 2'd1;
    localparam logic [SEL_W-1:0] ACC_C10 = 2'd2;
    localparam logic [SEL_W-1:0] ACC_C11 = 2'd3;

    localparam int RES_C00 = 0;
    localparam int RES_C01 = ACC_W;
    localparam int RES_C10 = 2 * ACC_W;
    localparam int RES_C11 = 3 * ACC_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/matrix_mac_accum.sv
// Sequenced multiply-accumulate of selected A/B elements into C = A x B.
// Pairs must arrive in index order 0..7; result latches one cycle after idx 7.
module matrix_mac_accum
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              elem_valid,
    input  logic [IDX_W-1:0]  entry_in,
    input  logic [ELEM_W-1:0] a_elem,
    input  logic [ELEM_W-1:0] b_elem,
    output logic [RES_W-1:0]  result,
    output logic              done,
    output logic              busy,
    output logic              seq_err
);

    state_t state, state_nxt;

    logic [IDX_W-1:0]  exp_idx;
    logic [ACC_W-1:0]  acc [ACC_N];
    logic [PROD_W-1:0] prod;
    logic [SEL_W-1:0]  sel;
    logic              in_order;
    logic              accept;
    logic              reject;
    logic              clear;

    assign prod = PROD_W'(a_elem) * PROD_W'(b_elem);
    assign sel  = entry_in[2:1];
    assign busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        accept    = 1'b0;
        reject    = 1'b0;
        in_order  = (entry_in == exp_idx) &&
                    (entry_in <= IDX_W'(LAST_IDX));
        case (state)
            IDLE: begin
                if (start) begin
                    clear     = 1'b1;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                // a restart discards whatever pair shares its cycle
                if (start) begin
                    clear = 1'b1;
                end else if (elem_valid) begin
                    if (in_order) begin
                        accept = 1'b1;
                        if (entry_in == IDX_W'(LAST_IDX))
                            state_nxt = DONE;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ACC_N; i++)
                acc[i] <= '0;
            exp_idx <= '0;
            seq_err <= 1'b0;
            result  <= '0;
            done    <= 1'b0;
        end else begin
            done <= (state == DONE);
            if (state == DONE) begin
                result[RES_C00 +: ACC_W] <= acc[ACC_C00];
                result[RES_C01 +: ACC_W] <= acc[ACC_C01];
                result[RES_C10 +: ACC_W] <= acc[ACC_C10];
                result[RES_C11 +: ACC_W] <= acc[ACC_C11];
            end
            if (clear) begin
                for (int i = 0; i < ACC_N; i++)
                    acc[i] <= '0;
                exp_idx <= '0;
                seq_err <= 1'b0;
            end else if (accept) begin
                acc[sel] <= acc[sel] + ACC_W'(prod);
                exp_idx  <= exp_idx + IDX_W'(1);
            end else if (reject) begin
                seq_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_matrix_mac_accum.sv
// Randomized bench for matrix_mac_accum against a plain 2x2 matrix product.
// Inputs change on negedge; outputs are checked on the following negedge.
module tb_matrix_mac_accum;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        elem_valid;
    logic [3:0]  entry_in;
    logic [2:0]  a_elem;
    logic [2:0]  b_elem;
    logic [27:0] result;
    logic        done;
    logic        busy;
    logic        seq_err;

    int checks;
    int fails;
    int done_cnt;

    int ma [4];
    int mb [4];

    matrix_mac_accum dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .elem_valid (elem_valid),
        .entry_in   (entry_in),
        .a_elem     (a_elem),
        .b_elem     (b_elem),
        .result     (result),
        .done       (done),
        .busy       (busy),
        .seq_err    (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    // C[i][j] = sum_k A[i][k] * B[k][j], packed c00,c01,c10,c11 from LSB
    function automatic logic [27:0] model_c();
        logic [27:0] r;
        int c;
        r = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                c = ma[i*2] * mb[j] + ma[i*2+1] * mb[2+j];
                r[(i*2+j)*7 +: 7] = c[6:0];
            end
        return r;
    endfunction

    task automatic set_random();
        for (int i = 0; i < 4; i++) begin
            ma[i] = $urandom_range(0, 7);
            mb[i] = $urandom_range(0, 7);
        end
    endtask

    // apply inputs, let one posedge pass, return on the next negedge
    task automatic drive_cycle(input logic s, input logic v,
                               input int idx, input int a, input int b);
        start      = s;
        elem_valid = v;
        entry_in   = idx[3:0];
        a_elem     = a[2:0];
        b_elem     = b[2:0];
        @(negedge clk);
    endtask

    task automatic drive_pair(input int idx, input logic s);
        int i, j, k;
        i = idx >> 2;
        j = (idx >> 1) & 1;
        k = idx & 1;
        drive_cycle(s, 1'b1, idx, ma[i*2+k], mb[k*2+j]);
    endtask

    task automatic drive_idle(input int n);
        for (int c = 0; c < n; c++)
            drive_cycle(1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic drive_pairs(input int lo, input int hi);
        for (int x = lo; x <= hi; x++)
            drive_pair(x, 1'b0);
    endtask

    task automatic test_reset();
        checks++;
        if (result !== 28'h0) begin
            fails++;
            $display("FAIL reset_result got %h want 0", result);
        end
        checks++;
        if ({done, busy, seq_err} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags got %b want 000", {done, busy, seq_err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        ma = '{1, 1, 1, 1};
        mb = '{1, 1, 1, 1};
        drive_pair(0, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_ignores_valid got busy=%b want 0", busy);
        end
    endtask

    task automatic test_normal();
        int d0;
        ma = '{1, 2, 3, 4};
        mb = '{5, 6, 7, 0};
        d0 = done_cnt;
        drive_cycle(1'b1, 1'b0, 0, 0, 0);
        drive_pairs(0, 7);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL normal_after_idx7 got done=%b busy=%b want 0 1",
                     done, busy);
        end
        drive_idle(1);
        checks++;
        if (done !== 1'b1 || result !== {7'd18, 7'd43, 7'd6, 7'd19}) begin
            fails++;
            $display("FAIL normal_result got done=%b %h want 1 %h",
                     done, result, {7'd18, 7'd43, 7'd6, 7'd19});
        end
        checks++;
        if (result !== model_c()) begin
            fails++;
            $display("FAIL normal_model got %h want %h", result, model_c());
        end
        drive_idle(1);
        checks++;
        if (done !== 1'b0 || done_cnt - d0 != 1) begin
            fails++;
            $display("FAIL normal_done_pulse got done=%b pulses=%0d want 0 1",
                     done, done_cnt - d0);
        end
    endtask

    task automatic test_max();
        for (int i = 0; i < 4; i++) begin
            ma[i] = 7;
            mb[i] = 7;
        end
        drive_cycle(1'b1, 1'b0, 0, 0, 0);
        drive_pairs(0, 7);
        drive_idle(1);
        checks++;
        if (result !== {4{7'd98}} || done !== 1'b1) begin
            fails++;
            $display("FAIL max_result got %h done=%b want %h 1",
                     result, done, {4{7'd98}});
        end
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL max_busy got %b want 0", busy);
        end
        drive_idle(1);
    endtask

    task automatic test_gaps();
        int d0;
        ma = '{1, 2, 3, 4};
        mb = '{5, 6, 7, 0};
        d0 = done_cnt;
        drive_cycle(1'b1, 1'b0, 0, 0, 0);
        drive_pairs(0, 3);
        for (int g = 0; g < 3; g++) begin
            drive_idle(1);
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                fails++;
                $display("FAIL gap_hold got busy=%b done=%b want 1 0",
                         busy, done);
            end
        end
        drive_pairs(4, 7);
        checks++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL gap_early_done got %b want 0", done);
        end
        drive_idle(1);
        checks++;
        if (done !== 1'b1 || result !== model_c()) begin
            fails++;
            $display("FAIL gap_result got done=%b %h want 1 %h",
                     done, result, model_c());
        end
        drive_idle(1);
        checks++;
        if (done_cnt - d0 != 1) begin
            fails++;
            $display("FAIL gap_pulses got %0d want 1", done_cnt - d0);
        end
    endtask

    task automatic test_seq_err();
        set_random();
        drive_cycle(1'b1, 1'b0, 0, 0, 0);
        drive_pairs(0, 1);
        checks++;
        if (seq_err !== 1'b0) begin
            fails++;
            $display("FAIL seq_err_early got %b want 0", seq_err);
        end
        drive_pair(3, 1'b0);
        checks++;
        if (seq_err !== 1'b1) begin
            fails++;
            $display("FAIL seq_err_set got %b want 1", seq_err);
        end
        drive_cycle(1'b0, 1'b1, 9, 7, 7);
        drive_pairs(2, 7);
        drive_idle(1);
        checks++;
        if (done !== 1'b1 || result !== model_c() || seq_err !== 1'b1) begin
            fails++;
            $display("FAIL seq_err_result got done=%b %h err=%b want 1 %h 1",
                     done, result, seq_err, model_c());
        end
        drive_idle(2);
        checks++;
        if (seq_err !== 1'b1) begin
            fails++;
            $display("FAIL seq_err_sticky got %b want 1", seq_err);
        end
        drive_cycle(1'b1, 1'b0, 0, 0, 0);
        checks++;
        if (seq_err !== 1'b0) begin
            fails++;
            $display("FAIL seq_err_clear got %b want 0", seq_err);
        end
        drive_pairs(0, 7);
        drive_idle(2);
    endtask

    task automatic test_restart();
        logic [27:0] prev;
        set_random();
        drive_cycle(1'b1, 1'b0, 0, 0, 0);
        drive_pairs(0, 7);
        drive_idle(2);
        prev = model_c();
        checks++;
        if (result !== prev) begin
            fails++;
            $display("FAIL restart_first got %h want %h", result, prev);
        end
        set_random();
        drive_cycle(1'b1, 1'b0, 0, 0, 0);
        drive_pairs(0, 4);
        drive_pair(5, 1'b1);
        set_random();
        drive_pairs(0, 4);
        checks++;
        if (result !== prev || busy !== 1'b1) begin
            fails++;
            $display("FAIL restart_hold got %h busy=%b want %h 1",
                     result, busy, prev);
        end
        drive_pairs(5, 7);
        drive_idle(1);
        checks++;
        if (done !== 1'b1 || result !== model_c()) begin
            fails++;
            $display("FAIL restart_result got done=%b %h want 1 %h",
                     done, result, model_c());
        end
        drive_idle(1);
    endtask

    task automatic test_async_reset();
        set_random();
        drive_cycle(1'b1, 1'b0, 0, 0, 0);
        drive_pairs(0, 3);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (result !== 28'h0 || {done, busy, seq_err} !== 3'b000) begin
            fails++;
            $display("FAIL async_reset got %h flags=%b want 0 000",
                     result, {done, busy, seq_err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_random();
        drive_cycle(1'b1, 1'b0, 0, 0, 0);
        drive_pairs(0, 7);
        drive_idle(1);
        checks++;
        if (done !== 1'b1 || result !== model_c()) begin
            fails++;
            $display("FAIL async_after got done=%b %h want 1 %h",
                     done, result, model_c());
        end
        drive_idle(1);
    endtask

    task automatic test_back_to_back();
        for (int p = 0; p < 6; p++) begin
            set_random();
            drive_cycle(1'b1, 1'b0, 0, 0, 0);
            for (int x = 0; x < 8; x++) begin
                drive_idle($urandom_range(0, 2));
                drive_pair(x, 1'b0);
            end
            // start during the DONE cycle must be ignored
            drive_cycle(1'b1, 1'b0, 0, 0, 0);
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || result !== model_c()) begin
                fails++;
                $display("FAIL b2b_pass%0d got done=%b busy=%b %h want 1 0 %h",
                         p, done, busy, result, model_c());
            end
        end
        drive_idle(1);
    endtask

    initial begin
        checks     = 0;
        fails      = 0;
        done_cnt   = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        elem_valid = 1'b0;
        entry_in   = '0;
        a_elem     = '0;
        b_elem     = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_normal();
        test_max();
        test_gaps();
        test_seq_err();
        test_restart();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
